// File: rtl/vec_core_pkg.sv
// Shared types and helpers for the vec_core vector micro-engine:
// opcode encoding, instruction field positions and lane saturation.
package vec_core_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MOV   = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_MUL   = 3'd4,
        OP_SCALE = 3'd5,
        OP_OUT   = 3'd6,
        OP_HALT  = 3'd7
    } opcode_e;

    // Working width for pre-saturation results; must be at least 2*W.
    localparam int SAT_XW = 64;

    function automatic int op_lsb(input int ra);
        return 3 * ra;
    endfunction

    function automatic int dst_lsb(input int ra);
        return 2 * ra;
    endfunction

    function automatic int a_lsb(input int ra);
        return ra;
    endfunction

    function automatic logic signed [SAT_XW-1:0] sat_w(input logic signed [SAT_XW-1:0] x,
                                                       input int w);
        logic signed [SAT_XW-1:0] hi;
        logic signed [SAT_XW-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// One signed fixed-point lane: move, add, subtract or Q-format multiply,
// saturated to W bits with a flag for any clipped result.
module vec_alu_lane
    import vec_core_pkg::*;
#(
    parameter int W    = 18,
    parameter int FRAC = 14
) (
    input  opcode_e               op,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [W-1:0]   y,
    output logic                  sat_o
);

    logic signed [2*W-1:0]    prod;
    logic signed [SAT_XW-1:0] wide;
    logic signed [SAT_XW-1:0] clip;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        prod = (2*W)'(a) * (2*W)'(b);
        wide = SAT_XW'(a);
        case (op)
            OP_ADD:           wide = SAT_XW'(a) + SAT_XW'(b);
            OP_SUB:           wide = SAT_XW'(a) - SAT_XW'(b);
            OP_MUL, OP_SCALE: wide = SAT_XW'(prod >>> FRAC);
            default:          wide = SAT_XW'(a);
        endcase
        clip  = sat_w(wide, W);
        y     = clip[W-1:0];
        sat_o = (clip != wide);
    end

endmodule

// File: rtl/vec_core.sv
// Vector micro-engine: program RAM, vector register file and a two-state
// sequencer executing one instruction per clock with streamed OUT results.
module vec_core
    import vec_core_pkg::*;
#(
    parameter int W      = 18,
    parameter int FRAC   = 14,
    parameter int LANES  = 3,
    parameter int NIN    = 3,
    parameter int NREG   = 8,
    parameter int PDEPTH = 32,
    localparam int RA    = $clog2(NREG),
    localparam int PA    = $clog2(PDEPTH),
    localparam int IW    = 3 + 3 * RA,
    localparam int VW    = LANES * W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [PA-1:0]         prog_addr,
    input  logic [IW-1:0]         prog_data,
    input  logic                  start,
    input  logic [PA-1:0]         start_pc,
    input  logic                  abort,
    input  logic [NIN*VW-1:0]     in_vec,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic                  sat,
    output logic [VW-1:0]         out_vec,
    output logic                  out_valid
);

    typedef enum logic {S_IDLE, S_EXEC} state_e;

    localparam int OP_LSB  = op_lsb(RA);
    localparam int DST_LSB = dst_lsb(RA);
    localparam int A_LSB   = a_lsb(RA);

    state_e          state_q, state_d;
    logic [PA-1:0]   pc_q, pc_d;
    logic [VW-1:0]   regs_q [NREG];
    logic [VW-1:0]   regs_d [NREG];
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            sat_q, sat_d;
    logic [VW-1:0]   out_vec_q, out_vec_d;
    logic            out_valid_q, out_valid_d;

    logic [IW-1:0]   prog_mem [PDEPTH];
    logic [IW-1:0]   instr;
    opcode_e         op;
    logic [RA-1:0]   dst, ra_sel, rb_sel;
    logic [VW-1:0]   a_vec, b_vec, alu_vec;
    logic [LANES-1:0] lane_sat;

    // NOTE: program RAM has no reset so it maps onto plain RAM and survives rst.
    always_ff @(posedge clk) begin
        if (prog_we && state_q == S_IDLE)
            prog_mem[prog_addr] <= prog_data;
    end

    assign instr  = prog_mem[pc_q];
    assign op     = opcode_e'(instr[OP_LSB +: 3]);
    assign dst    = instr[DST_LSB +: RA];
    assign ra_sel = instr[A_LSB +: RA];
    assign rb_sel = instr[RA-1:0];
    assign a_vec  = regs_q[ra_sel];
    assign b_vec  = regs_q[rb_sel];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        vec_alu_lane #(.W(W), .FRAC(FRAC)) u_lane (
            .op    (op),
            .a     (a_vec[j*W +: W]),
            .b     ((op == OP_SCALE) ? b_vec[0 +: W] : b_vec[j*W +: W]),
            .y     (alu_vec[j*W +: W]),
            .sat_o (lane_sat[j])
        );
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        regs_d      = regs_q;
        done_d      = 1'b0;
        err_d       = err_q;
        sat_d       = sat_q;
        out_vec_d   = out_vec_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EXEC;
                    pc_d    = start_pc;
                    err_d   = 1'b0;
                    sat_d   = 1'b0;
                    for (int i = 0; i < NIN; i++)
                        regs_d[i] = in_vec[i*VW +: VW];
                end
            end
            S_EXEC: begin
                // Abort wins over everything: the instruction at pc is dropped.
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    pc_d = pc_q + PA'(1);
                    case (op)
                        OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_SCALE: begin
                            regs_d[dst] = alu_vec;
                            sat_d       = sat_q | (|lane_sat);
                        end
                        OP_OUT: begin
                            out_vec_d   = a_vec;
                            out_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                    if (op == OP_HALT) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (pc_q == PA'(PDEPTH - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sat_q       <= 1'b0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sat_q       <= sat_d;
            out_vec_q   <= out_vec_d;
            out_valid_q <= out_valid_d;
            regs_q      <= regs_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign sat       = sat_q;
    assign out_vec   = out_vec_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vec_core.sv
// Directed bench for vec_core: expected OUT vectors go into a scoreboard
// queue and a negedge monitor compares each out_valid beat against it.
module tb_vec_core;
    import vec_core_pkg::*;

    localparam int W = 18, LANES = 3, NIN = 3, VW = LANES * W;

    logic               clk = 1'b0;
    logic               rst;
    logic               prog_we;
    logic [4:0]         prog_addr;
    logic [11:0]        prog_data;
    logic               start;
    logic [4:0]         start_pc;
    logic               abort;
    logic [NIN*VW-1:0]  in_vec;
    logic               ready, done, err, sat, out_valid;
    logic [VW-1:0]      out_vec;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [VW-1:0]      exp_q [$];

    always #5 clk = ~clk;

    vec_core dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .start_pc  (start_pc),
        .abort     (abort),
        .in_vec    (in_vec),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .sat       (sat),
        .out_vec   (out_vec),
        .out_valid (out_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ins(input opcode_e op, input int d, input int a, input int b);
        return {op, 3'(d), 3'(a), 3'(b)};
    endfunction

    function automatic logic [VW-1:0] v3(input int l0, input int l1, input int l2);
        return {18'(l2), 18'(l1), 18'(l0)};
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got %0h expected no output", out_vec);
            end else begin
                check("out_vec", 64'(out_vec), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic load(input int addr, input logic [11:0] data);
        prog_addr = 5'(addr);
        prog_data = data;
        prog_we   = 1'b1;
        @(posedge clk); #1;
        prog_we   = 1'b0;
    endtask

    // Start at pc; optionally abort or poke start/prog_we on a given edge.
    task automatic run(input int pc, input int abort_at, input int poke_at,
                       output int done_edge, output logic sat0);
        start_pc = 5'(pc);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        sat0     = sat;
        done_edge = 0;
        for (int k = 1; k <= 64; k++) begin
            if (k == abort_at) abort = 1'b1;
            if (k == poke_at) begin
                start     = 1'b1;
                start_pc  = 5'd24;
                prog_we   = 1'b1;
                prog_addr = 5'd5;
                prog_data = ins(OP_HALT, 0, 0, 0);
            end
            @(posedge clk); #1;
            abort   = 1'b0;
            start   = 1'b0;
            prog_we = 1'b0;
            if (done) begin
                done_edge = k;
                break;
            end
            if (abort_at != 0 && k >= abort_at + 3) break;
        end
    endtask

    logic [NIN*VW-1:0] in_t2, in_t3, in_t4;
    int   de;
    logic s0;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; start_pc = '0; in_vec = '0;
        in_t2 = {v3(0, 0, 0), v3(16384, 16384, 16384), v3(16384, 32768, -16384)};
        in_t3 = {v3(-131072, 0, 0), v3(1, 1, 1), v3(131071, 0, 0)};
        in_t4 = {v3(-16384, 0, 0), v3(8192, -32768, 32768), v3(8192, -32768, 114688)};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_vec", 64'(out_vec), 64'd0);
        @(posedge clk); #1;

        load(0, ins(OP_ADD, 3, 0, 1));   load(1, ins(OP_OUT, 0, 3, 0));   load(2, ins(OP_HALT, 0, 0, 0));
        load(4, ins(OP_ADD, 3, 0, 1));   load(5, ins(OP_SUB, 4, 2, 1));   load(6, ins(OP_OUT, 0, 3, 0));
        load(7, ins(OP_OUT, 0, 4, 0));   load(8, ins(OP_HALT, 0, 0, 0));
        load(10, ins(OP_MUL, 3, 0, 1));  load(11, ins(OP_SCALE, 4, 0, 2)); load(12, ins(OP_OUT, 0, 3, 0));
        load(13, ins(OP_OUT, 0, 4, 0));  load(14, ins(OP_HALT, 0, 0, 0));
        load(16, ins(OP_OUT, 0, 0, 0));  load(17, ins(OP_OUT, 0, 1, 0));  load(18, ins(OP_MOV, 7, 1, 0));
        load(19, ins(OP_OUT, 0, 2, 0));  load(20, ins(OP_HALT, 0, 0, 0));
        load(24, ins(OP_OUT, 0, 7, 0));  load(25, ins(OP_HALT, 0, 0, 0));
        load(31, ins(OP_NOP, 0, 0, 0));

        // Basic ADD / OUT / HALT
        in_vec = in_t2;
        exp_q.push_back(v3(32768, 49152, 0));
        run(0, 0, 0, de, s0);
        check("t2_done_edge", 64'(de), 64'd3);
        check("t2_ready", 64'(ready), 64'd1);
        check("t2_err", 64'(err), 64'd0);
        check("t2_sat", 64'(sat), 64'd0);
        check("t2_out_hold", 64'(out_vec), 64'(v3(32768, 49152, 0)));

        // Saturating ADD / SUB
        in_vec = in_t3;
        exp_q.push_back(v3(131071, 1, 1));
        exp_q.push_back(v3(-131072, -1, -1));
        run(4, 0, 0, de, s0);
        check("t3_done_edge", 64'(de), 64'd5);
        check("t3_sat", 64'(sat), 64'd1);
        check("t3_err", 64'(err), 64'd0);
        in_vec = in_t2;
        exp_q.push_back(v3(32768, 49152, 0));
        run(0, 0, 0, de, s0);
        check("t3_sat_clear_at_start", 64'(s0), 64'd0);
        check("t3b_done_edge", 64'(de), 64'd3);
        check("t3b_sat", 64'(sat), 64'd0);

        // MUL with saturation, SCALE by -1.0
        in_vec = in_t4;
        exp_q.push_back(v3(4096, 65536, 131071));
        exp_q.push_back(v3(-8192, 32768, -114688));
        run(10, 0, 0, de, s0);
        check("t4_done_edge", 64'(de), 64'd5);
        check("t4_sat", 64'(sat), 64'd1);

        // Overrun at the last program word
        run(31, 0, 0, de, s0);
        check("t5_done_edge", 64'(de), 64'd1);
        check("t5_err", 64'(err), 64'd1);
        check("t5_ready", 64'(ready), 64'd1);

        // Abort on edge 2: only the first OUT appears, MOV R7 never runs
        in_vec = in_t2;
        exp_q.push_back(v3(16384, 32768, -16384));
        run(16, 2, 0, de, s0);
        check("t6a_no_done", 64'(de), 64'd0);
        check("t6a_ready", 64'(ready), 64'd1);
        check("t6a_err_cleared", 64'(err), 64'd0);
        exp_q.push_back(v3(0, 0, 0));
        run(24, 0, 0, de, s0);
        check("t6a_r7_done_edge", 64'(de), 64'd2);

        // start and prog_we while busy are ignored
        in_vec = in_t3;
        exp_q.push_back(v3(131071, 1, 1));
        exp_q.push_back(v3(-131072, -1, -1));
        run(4, 0, 2, de, s0);
        check("t6b_done_edge", 64'(de), 64'd5);
        exp_q.push_back(v3(131071, 1, 1));
        exp_q.push_back(v3(-131072, -1, -1));
        run(4, 0, 0, de, s0);
        check("t6c_rerun_done_edge", 64'(de), 64'd5);

        repeat (2) @(posedge clk); #1;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_core.md
# vec_core

Parametrised fixed-point vector micro-engine, the successor to the 3×3-input, 18-bit `uCore`. It executes a small writable program over a vector register file. Input vectors are latched at start. Results stream out through an `OUT` instruction, and completion is signalled with a `done` pulse. It sits between the sensor-fusion front end and the attitude controller, and generalises lane count, width, input count, register count and program depth. It adds saturation, program load, abort and overrun detection.

## Interface
- `W`, 18: lane width, signed two's complement
- `FRAC`, 14: fractional bits (Q format)
- `LANES`, 3: lanes per vector
- `NIN`, 3: input vectors; must be less than `NREG`
- `NREG`, 8: vector registers, power of 2; `RA`=clog2(`NREG`)
- `PDEPTH`, 32: program words, power of 2; `PA`=clog2(`PDEPTH`)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `prog_we`  in  1  program write strobe
- `prog_addr`  in  `PA`  program write address
- `prog_data`  in  3+3·`RA`  instruction word
- `start`  in  1  start request
- `start_pc`  in  `PA`  first instruction address
- `abort`  in  1  cancel the running program
- `in_vec`  in  `NIN`·`LANES`·`W`  input i, lane j at bits [(i·`LANES`+j)·`W` +: `W`]
- `ready`  out  1  idle; accepts `start` and `prog_we`
- `done`  out  1  one-cycle pulse when a run completes
- `err`  out  1  sticky overrun flag
- `sat`  out  1  sticky saturation flag
- `out_vec`  out  `LANES`·`W`  last value written by `OUT`
- `out_valid`  out  1  one-cycle pulse per `OUT`

## Operation
- Instruction word fields: op [3RA+2:3RA], dst [3RA-1:2RA], a [2RA-1:RA], b [RA-1:0].
- Opcodes:
  - 0 `NOP`
  - 1 `MOV`: dst←a
  - 2 `ADD`: dst←a+b
  - 3 `SUB`: dst←a−b
  - 4 `MUL`: lanewise (a·b)>>>FRAC
  - 5 `SCALE`: dst←(a·b[lane0])>>>FRAC
  - 6 `OUT`: out_vec←a, out_valid pulses
  - 7 `HALT`
- Arithmetic:
  - Every result is saturated to [−2^(W−1), 2^(W−1)−1].
  - Products are computed at full 2W width, arithmetic-shifted right by FRAC (rounding toward −∞), then saturated.
  - Any clipped lane sets `sat`.
- State machine:
  - IDLE→EXEC on `start` (valid only in IDLE). On that edge, R0..R(NIN−1)←`in_vec`, pc←`start_pc`, and `err` and `sat` clear.
  - EXEC executes one instruction per edge at pc, then pc←pc+1.
    - `HALT` → IDLE with `done`=1.
    - A non-HALT instruction at pc=PDEPTH−1 commits its effect, then → IDLE with `done`=1 and `err`=1. There is no wrap-around.
  - `abort` in EXEC → IDLE at that edge. The instruction at pc is not executed, and there is no `done`. `abort` has priority over `HALT` and overrun.
- Register R(NIN)..R(NREG−1) contents persist across runs. Any register, including input registers, may be a destination.
- `prog_we` is honoured only when `ready`=1. If it coincides with `start`, the write still commits.
- `start`, `start_pc` and `prog_we` are ignored while busy.
- Program memory is not reset. Registers reset to 0.

## Timing
- Reset values: `ready`=1; `done`, `err`, `sat`, `out_valid`=0; `out_vec`=0; state IDLE.
- `ready` falls on the edge after `start` is accepted, and rises on the same edge that raises `done`.
- The instruction at `start_pc`+k executes on edge k+1 after the start edge.
  - A program of N words ending in `HALT` raises `done` N edges after start.
- `out_valid` and `out_vec` update on the `OUT` execute edge. `out_vec` holds until the next `OUT` or reset.
- Read-after-write needs no stall: a register written on edge n is read by the instruction at edge n+1.
- An asynchronous `rst` mid-run returns all state to reset values immediately. The program is retained.

## Structure
- Package `vec_core_pkg` holds:
  - the opcode enum;
  - field-position functions of `RA`;
  - a `sat_w` saturation function.
- Sub-module `vec_alu_lane` is a single-lane add/sub/mul with saturation and a sat flag out. It is instantiated `LANES` times.
- The core holds the FSM, pc, register file and program RAM (inferred).

## Test plan
All values use defaults; 1.0 = 16384.
1. Reset → `ready`=1, `done`/`err`/`sat`/`out_valid`=0, `out_vec`=0.
2. Program {`ADD` R3,R0,R1; `OUT` R3; `HALT`} at 0, `start_pc`=0, R0=(16384,32768,−16384), R1=(16384,16384,16384) → `out_valid` on edge 2 with `out_vec`=(32768,49152,0); `done` on edge 3, `ready` returns, `err`=0, `sat`=0.
3. `ADD` with 131071+1 → 131071 and `sat`=1. `SUB` with −131072−1 → −131072. `sat` clears on the next start.
4. `MUL` (8192,−32768,114688)·(8192,−32768,32768) → (4096,65536,131071), `sat`=1. `SCALE` by b lane0 = −16384 negates a.
5. `start_pc`=31 with `NOP` stored there → `done`=1 and `err`=1 on edge 1.
6. Abort and ignore rules:
   - `abort` on edge 2 of a 5-instruction program → no `done`, `ready`=1, later instructions not executed.
   - `start` while busy → ignored.
   - `prog_we` while busy → memory unchanged, verified by a re-run.
